sram_controller: RTL and testbench

//  MEM-stage access controller between the EXE/MEM pipeline register and the

---
 rtl/sram_controller_pkg.sv | 16 +
 rtl/sram_controller_if.sv | 22 ++
 rtl/sram_controller_wait_counter.sv | 25 ++
 rtl/sram_controller.sv | 100 ++++++++++
 tb/tb_sram_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller:
// FSM state encoding and SRAM geometry constants.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SRAM_BASE_ADDR = 1024;
  localparam int SRAM_DATA_W    = 16;
  localparam int MAX_WAIT       = 7;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side load/store handshake between the EXE/MEM register and the
// SRAM controller; the controller uses the slave modport.
interface sram_controller_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, dataIn,
    input  dataOut, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, dataIn,
    output dataOut, ready
  );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Per-phase wait-state counter: clears at phase boundaries and flags the
// last cycle of a phase (count == WAIT_CYCLES).
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic term
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign term = (cnt == 3'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half,
// then high half) with programmable wait states; stalls the pipeline via ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int IDX_W = SRAM_ADDR_W - 1;

  state_t           state;
  logic             term;
  logic             busy;
  logic             req;
  logic             wr;
  logic             rd;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [31:0]      data_reg;

  // A simultaneous read+write request is handled as a plain write.
  assign req    = bus.mem_r_en | bus.mem_w_en;
  assign wr     = bus.mem_w_en;
  assign rd     = bus.mem_r_en & ~bus.mem_w_en;
  assign offset = bus.address - 32'(BASE_ADDR);
  assign idx    = IDX_W'(offset >> 2);
  assign busy   = (state == LO) || (state == HI);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(~busy | term),
    .en   (busy),
    .term (term)
  );

  // SRAM strobes are set up on the edge entering each phase so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      data_reg    <= '0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LO;
            sram_addr   <= {idx, 1'b0};
            sram_we_n   <= ~wr;
            sram_dq_oe  <= wr;
            sram_dq_out <= wr ? bus.dataIn[15:0] : '0;
          end
        end
        LO: begin
          if (term) begin
            if (rd) data_reg[15:0] <= sram_dq_in;
            state       <= HI;
            sram_addr   <= {idx, 1'b1};
            sram_dq_out <= wr ? bus.dataIn[31:16] : '0;
          end
        end
        HI: begin
          if (term) begin
            if (rd) data_reg[31:16] <= sram_dq_in;
            state       <= DONE;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready   = ~req | (state == DONE);
  assign bus.dataOut = bus.mem_r_en ? data_reg : '0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: transaction-level SRAM/data model,
// cycle-by-cycle output checks, directed scenarios and randomized traffic.
module tb_sram_controller;

  localparam int W      = 1;
  localparam int BASE   = 1024;
  localparam int DONE_K = 2 * W + 3;
  localparam int DEPTH  = 1 << 18;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  sram_controller_if bus ();

  sram_controller #(
    .BASE_ADDR  (BASE),
    .SRAM_ADDR_W(18),
    .WAIT_CYCLES(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: combinational read, write latched at each edge while strobed.
  logic [15:0] sram_mem [0:DEPTH-1];
  logic [15:0] ref_mem  [0:DEPTH-1];

  assign sram_dq_in = sram_mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_out;
  end

  int          tests = 0;
  int          failures = 0;
  int          cur_k = -1;
  logic [31:0] exp_data_reg;
  logic [31:0] last_done_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (k=%0d): got %h, expected %h", name, cur_k, act, exp);
    end
  endtask

  function automatic int wordIndex(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  // No request pending: everything quiet, ready high.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur_k = -1;
      checkOutput("idle ready", 32'(bus.ready), 32'd1);
      checkOutput("idle we_n", 32'(sram_we_n), 32'd1);
      checkOutput("idle oe", 32'(sram_dq_oe), 32'd0);
      checkOutput("idle dq_out", 32'(sram_dq_out), 32'd0);
      checkOutput("idle dataOut", bus.dataOut, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one whole transaction from the IDLE cycle through DONE, checking every cycle.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] addr,
                               input logic [31:0] data);
    int          idx;
    bit          wr;
    bit          rd;
    bit          in_lo;
    bit          in_hi;
    logic [15:0] lo_new;
    logic [15:0] hi_new;
    logic [31:0] old;
    logic [31:0] exp_out;
    logic [31:0] exp_dq;
    idx    = wordIndex(addr);
    wr     = w;
    rd     = r & ~w;
    old    = exp_data_reg;
    lo_new = ref_mem[2*idx];
    hi_new = ref_mem[2*idx+1];
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = addr;
    bus.dataIn   = data;
    for (int k = 0; k <= DONE_K; k++) begin
      @(negedge clk);
      cur_k = k;
      in_lo = (k >= 1) && (k <= W + 1);
      in_hi = (k >= W + 2) && (k <= 2 * W + 2);
      if (!r)             exp_out = 32'd0;
      else if (!rd)       exp_out = old;
      else if (k <= W + 1) exp_out = old;
      else if (k < DONE_K) exp_out = {old[31:16], lo_new};
      else                exp_out = {hi_new, lo_new};
      if (wr && in_lo)      exp_dq = {16'd0, data[15:0]};
      else if (wr && in_hi) exp_dq = {16'd0, data[31:16]};
      else                  exp_dq = 32'd0;
      checkOutput("ready", 32'(bus.ready), (k == DONE_K) ? 32'd1 : 32'd0);
      checkOutput("we_n", 32'(sram_we_n), (wr && (in_lo || in_hi)) ? 32'd0 : 32'd1);
      checkOutput("oe", 32'(sram_dq_oe), (wr && (in_lo || in_hi)) ? 32'd1 : 32'd0);
      checkOutput("dq_out", 32'(sram_dq_out), exp_dq);
      checkOutput("dataOut", bus.dataOut, exp_out);
      if (in_lo || in_hi) checkOutput("sram_addr", 32'(sram_addr), 32'(2 * idx + (in_hi ? 1 : 0)));
      if (k == DONE_K) last_done_data = bus.dataOut;
      @(posedge clk);
      #1;
    end
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    if (wr) begin
      ref_mem[2*idx]   = data[15:0];
      ref_mem[2*idx+1] = data[31:16];
    end
    if (rd) exp_data_reg = {hi_new, lo_new};
  endtask

  initial begin
    logic [31:0] addr;
    int          op;
    rst          = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = 32'd0;
    bus.dataIn   = 32'd0;
    exp_data_reg = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 16'($urandom);
      ref_mem[i]  = sram_mem[i];
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst ready", 32'(bus.ready), 32'd1);
    checkOutput("rst we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("rst sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst dq_out", 32'(sram_dq_out), 32'd0);
    checkOutput("rst dataOut", bus.dataOut, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    idleCycles(10);

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    checkOutput("store1024 lo", 32'(sram_mem[0]), 32'h0000BEEF);
    checkOutput("store1024 hi", 32'(sram_mem[1]), 32'h0000DEAD);

    applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0);
    checkOutput("load1024", last_done_data, 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h12345678);
    checkOutput("store1028 lo", 32'(sram_mem[2]), 32'h00005678);
    checkOutput("store1028 hi", 32'(sram_mem[3]), 32'h00001234);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0);
    checkOutput("load1024 again", last_done_data, 32'hDEADBEEF);

    // Reset while the low half of a store is being written
    bus.mem_w_en = 1'b1;
    bus.address  = 32'd1036;
    bus.dataIn   = 32'hAAAA5555;
    @(posedge clk);
    #1;
    @(negedge clk);
    cur_k = 1;
    checkOutput("abort pre we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_w_en = 1'b0;
    bus.mem_r_en = 1'b1;
    ref_mem[6]   = 16'h5555;
    exp_data_reg = 32'd0;
    @(negedge clk);
    checkOutput("abort we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("abort dq_out", 32'(sram_dq_out), 32'd0);
    checkOutput("abort sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("abort dataOut", bus.dataOut, 32'd0);
    checkOutput("abort ready", 32'(bus.ready), 32'd0);
    checkOutput("abort half lo", 32'(sram_mem[6]), 32'h00005555);
    checkOutput("abort half hi", 32'(sram_mem[7]), 32'(ref_mem[7]));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_r_en = 1'b0;
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0);
    checkOutput("load1028 after rst", last_done_data, 32'h12345678);

    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    checkOutput("rw keeps data_reg", last_done_data, 32'h12345678);
    checkOutput("rw store lo", 32'(sram_mem[4]), 32'h0000F00D);
    checkOutput("rw store hi", 32'(sram_mem[5]), 32'h0000CAFE);

    // Randomized traffic, mostly in a small window so loads hit earlier stores
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      case (op)
        0: applyStimulus(1'b1, 1'b0, addr, 32'd0);
        1: applyStimulus(1'b0, 1'b1, addr, $urandom);
        2: applyStimulus(1'b1, 1'b1, addr, $urandom);
        default: idleCycles(1);
      endcase
      idleCycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
